// File: rtl/entrada_tempo.sv
// entrada_tempo: keypad time entry that validates BCD digits and strobes them into the countdown counters
module entrada_tempo #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keys,
  input  logic       start,
  input  logic       cancel,
  input  logic       enable,
  input  logic       done,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic       load_n,
  output logic [1:0] digit_cnt,
  output logic       busy,
  output logic       key_err
);
  typedef enum logic [1:0] {EMPTY, ENTRY, LOAD, HOLD} state_t;
  state_t state, state_n;
  logic [9:0] key_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] start_pipe;
  logic [9:0] ks, ks_prev;
  logic ss, ss_prev, key_ev, start_ev, err_n, zero;
  logic [3:0] digit, su_n, st_n, mu_n;
  logic [1:0] cnt_n;
  assign ks = key_pipe[SYNC_STAGES-1];
  assign ss = start_pipe[SYNC_STAGES-1];
  // a new key event needs the whole pad to have been released in between
  assign key_ev = (ks != '0) && (ks_prev == '0);
  assign start_ev = ss && !ss_prev;
  assign load_n = state != LOAD;
  assign busy = (state == LOAD) || (state == HOLD);
  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) if (ks[i]) digit = 4'(i);
  end
  always_comb begin
    state_n = state;
    su_n = sec_units;
    st_n = sec_tens;
    mu_n = min_units;
    cnt_n = digit_cnt;
    err_n = 1'b0;
    case (state)
      EMPTY, ENTRY: begin
        if (start_ev) begin
          if (enable && (state == EMPTY || sec_tens > 4'(SEC_TENS_MAX))) err_n = 1'b1;
          else if (enable) state_n = LOAD;
        end else if (key_ev && enable) begin
          if (!$onehot(ks) || digit_cnt == 2'd3) err_n = 1'b1;
          else begin
            mu_n = sec_tens;
            st_n = sec_units;
            su_n = digit;
            cnt_n = digit_cnt + 2'd1;
            state_n = ENTRY;
          end
        end
      end
      LOAD: state_n = HOLD;
      default: ;
    endcase
    zero = cancel || (state == HOLD && done);
    if (zero) begin
      state_n = EMPTY;
      su_n = '0;
      st_n = '0;
      mu_n = '0;
      cnt_n = '0;
      err_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < SYNC_STAGES; i++) key_pipe[i] <= '0;
      start_pipe <= '0;
      ks_prev <= '0;
      ss_prev <= 1'b0;
      state <= EMPTY;
      sec_units <= '0;
      sec_tens <= '0;
      min_units <= '0;
      digit_cnt <= '0;
      key_err <= 1'b0;
    end else begin
      key_pipe[0] <= keys;
      for (int i = 1; i < SYNC_STAGES; i++) key_pipe[i] <= key_pipe[i-1];
      start_pipe <= {start_pipe[SYNC_STAGES-2:0], start};
      ks_prev <= ks;
      ss_prev <= ss;
      state <= state_n;
      sec_units <= su_n;
      sec_tens <= st_n;
      min_units <= mu_n;
      digit_cnt <= cnt_n;
      key_err <= err_n;
    end
  end
endmodule

// File: tb/tb_entrada_tempo.sv
// tb_entrada_tempo: directed checks of key entry, validation, load strobe and hold behaviour
module tb_entrada_tempo;
  logic clk = 1'b0, clear = 1'b0, start = 1'b0, cancel = 1'b0, enable = 1'b1, done = 1'b0;
  logic [9:0] keys = '0;
  logic [3:0] sec_units, sec_tens, min_units;
  logic load_n, busy, key_err;
  logic [1:0] digit_cnt;
  int nvec = 0, nerr = 0, err_cnt = 0, load_cnt = 0, e0, l0;
  entrada_tempo dut (.clk(clk), .clear(clear), .keys(keys), .start(start), .cancel(cancel),
    .enable(enable), .done(done), .sec_units(sec_units), .sec_tens(sec_tens),
    .min_units(min_units), .load_n(load_n), .digit_cnt(digit_cnt), .busy(busy), .key_err(key_err));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    err_cnt += int'(key_err);
    load_cnt += int'(!load_n);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int k);
    keys = 10'b1 << k;
    step(4);
    keys = '0;
    step(3);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step(4);
    start = 1'b0;
    step(3);
  endtask
  task automatic do_cancel();
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(1);
  endtask
  task automatic chk_digits(input string name, input logic [3:0] m, input logic [3:0] t,
                            input logic [3:0] u, input logic [1:0] c);
    if ({min_units, sec_tens, sec_units, digit_cnt} !== {m, t, u, c}) begin
      $display("FAIL %s: got m/t/u/cnt %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name,
               min_units, sec_tens, sec_units, digit_cnt, m, t, u, c);
      nerr++;
    end
    nvec++;
  endtask
  task automatic test_reset();
    step(2);
    chk_digits("reset_digits", 0, 0, 0, 0);
    if ({load_n, busy, key_err} !== 3'b100) begin
      $display("FAIL reset_ctrl: got load_n/busy/err %b want 100", {load_n, busy, key_err}); nerr++;
    end
    nvec++;
    clear = 1'b1;
    step(2);
  endtask
  task automatic test_load();
    press(1); press(3); press(0);
    chk_digits("load_entry", 1, 3, 0, 3);
    e0 = err_cnt; l0 = load_cnt;
    pulse_start();
    if (load_cnt - l0 !== 1) begin
      $display("FAIL load_pulse: got %0d low cycles want 1", load_cnt - l0); nerr++;
    end
    nvec++;
    if ({busy, load_n} !== 2'b11 || err_cnt != e0) begin
      $display("FAIL load_busy: got busy/load_n %b err %0d want 11 err 0", {busy, load_n}, err_cnt - e0); nerr++;
    end
    nvec++;
    chk_digits("load_kept", 1, 3, 0, 3);
    do_cancel();
  endtask
  task automatic test_overflow();
    e0 = err_cnt;
    press(1); press(2); press(3);
    if (err_cnt != e0) begin
      $display("FAIL ovf_noerr: got %0d errs want 0", err_cnt - e0); nerr++;
    end
    nvec++;
    press(4);
    chk_digits("ovf_digits", 1, 2, 3, 3);
    if (err_cnt - e0 !== 1) begin
      $display("FAIL ovf_err: got %0d errs want 1", err_cnt - e0); nerr++;
    end
    nvec++;
    do_cancel();
  endtask
  task automatic test_tens_limit();
    press(7); press(5);
    e0 = err_cnt; l0 = load_cnt;
    pulse_start();
    if (err_cnt - e0 !== 1 || load_cnt != l0 || busy !== 1'b0) begin
      $display("FAIL tens_reject: got errs %0d loads %0d busy %b want 1 0 0", err_cnt - e0, load_cnt - l0, busy); nerr++;
    end
    nvec++;
    chk_digits("tens_kept", 0, 7, 5, 2);
    do_cancel();
    chk_digits("tens_cancel", 0, 0, 0, 0);
  endtask
  task automatic test_multi_hold();
    e0 = err_cnt;
    keys = 10'b0000100100;
    step(4); keys = '0; step(3);
    if (err_cnt - e0 !== 1) begin
      $display("FAIL multi_err: got %0d errs want 1", err_cnt - e0); nerr++;
    end
    nvec++;
    chk_digits("multi_noshift", 0, 0, 0, 0);
    keys = 10'b1 << 4;
    step(20); keys = '0; step(3);
    chk_digits("held_key", 0, 0, 4, 1);
    do_cancel();
  endtask
  task automatic test_hold();
    press(1); press(2);
    pulse_start();
    e0 = err_cnt;
    press(8);
    pulse_start();
    chk_digits("hold_frozen", 0, 1, 2, 2);
    if (err_cnt != e0 || busy !== 1'b1) begin
      $display("FAIL hold_quiet: got errs %0d busy %b want 0 1", err_cnt - e0, busy); nerr++;
    end
    nvec++;
    done = 1'b1; step(1); done = 1'b0;
    chk_digits("done_clear", 0, 0, 0, 0);
    if (busy !== 1'b0) begin
      $display("FAIL done_busy: got %b want 0", busy); nerr++;
    end
    nvec++;
  endtask
  task automatic test_misc();
    e0 = err_cnt;
    pulse_start();
    if (err_cnt - e0 !== 1 || busy !== 1'b0) begin
      $display("FAIL empty_start: got errs %0d busy %b want 1 0", err_cnt - e0, busy); nerr++;
    end
    nvec++;
    enable = 1'b0; e0 = err_cnt;
    press(6);
    enable = 1'b1;
    chk_digits("disabled_key", 0, 0, 0, 0);
    if (err_cnt != e0) begin
      $display("FAIL disabled_err: got %0d want 0", err_cnt - e0); nerr++;
    end
    nvec++;
    press(3);
    l0 = load_cnt;
    start = 1'b1; step(2);
    cancel = 1'b1; step(1);
    cancel = 1'b0; start = 1'b0; step(3);
    chk_digits("cancel_start", 0, 0, 0, 0);
    if (load_cnt != l0 || busy !== 1'b0) begin
      $display("FAIL cancel_noload: got loads %0d busy %b want 0 0", load_cnt - l0, busy); nerr++;
    end
    nvec++;
    press(2);
    start = 1'b1; step(3);
    if (load_n !== 1'b0) begin
      $display("FAIL pre_clear_load: got load_n %b want 0", load_n); nerr++;
    end
    nvec++;
    clear = 1'b0; #1;
    if ({load_n, busy} !== 2'b10) begin
      $display("FAIL async_clear: got load_n/busy %b want 10", {load_n, busy}); nerr++;
    end
    nvec++;
    start = 1'b0; #1 clear = 1'b1;
    step(2);
  endtask
  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_tens_limit();
    test_multi_hold();
    test_hold();
    test_misc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/entrada_tempo.md
Name: entrada_tempo

Overview:
Keypad time-entry stage of the microwave timer, directly upstream of the digit counter chain (mod-10 seconds units, mod-6 seconds tens, minutes units).
- Captures decimal keystrokes and shifts them into three BCD digit registers.
- On start, validates the entry and drives the counters' parallel data inputs with a one-cycle active-low load strobe.
- Holds the loaded value until the cook cycle finishes or is cancelled.

Parameters:
SYNC_STAGES, 2, synchroniser depth on keys and start (min 2)
SEC_TENS_MAX, 5, largest legal seconds-tens digit

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous active-low reset
keys  input  10  raw keypad, bit i high = key i pressed, asynchronous
start  input  1  raw start button, active-high, asynchronous
cancel  input  1  synchronous cancel/clear-entry, active-high
enable  input  1  entry permitted (door closed, controller idle)
done  input  1  one-cycle pulse from controller: countdown finished
sec_units  output  4  BCD seconds units, to counter data
sec_tens  output  4  BCD seconds tens, to mod-6 counter data
min_units  output  4  BCD minutes units, to counter data
load_n  output  1  active-low load strobe to all counters
digit_cnt  output  2  digits entered (0..3)
busy  output  1  high in LOAD and HOLD
key_err  output  1  one-cycle error pulse

Behaviour:
Reset (clear low, asynchronous):
- All digit registers 0; digit_cnt 0; load_n 1; busy 0; key_err 0.
- State EMPTY; synchronisers cleared.

Input conditioning:
- keys and start each pass through SYNC_STAGES flops.
- Key event: synchronised keys nonzero this cycle AND all-zero the previous cycle.
  - Exactly one bit set: digit = index of the set bit.
  - More than one bit set: invalid, key_err pulse, no shift.
- After any key event, another event requires all keys released first; holding a key gives one event.
- Start event: rising edge of synchronised start.
- Latency: a key or start first sampled high at edge N is acted on at edge N+SYNC_STAGES.

States:
- EMPTY: digits 0, digit_cnt 0.
  - Valid key event with enable=1: shift in digit, digit_cnt=1, go to ENTRY.
  - Start event: key_err pulse, stay in EMPTY.
- ENTRY: valid key event with enable=1:
  - digit_cnt<3: shift min_units<=sec_tens, sec_tens<=sec_units, sec_units<=digit; digit_cnt+1.
  - digit_cnt=3: key ignored, key_err pulse.
- ENTRY: start event with enable=1:
  - sec_tens>SEC_TENS_MAX: key_err pulse, stay in ENTRY, digits kept.
  - Otherwise: go to LOAD.
- LOAD: load_n=0 for exactly one cycle, digits stable, busy=1; next state HOLD.
- HOLD: load_n=1, busy=1, digits frozen.
  - Keys and start ignored, no key_err.
  - done or cancel: go to EMPTY and zero the digits.
- enable=0: key and start events in EMPTY/ENTRY are discarded silently (edge still consumed); cancel still honoured.

Priority in the same cycle:
- cancel > start > key; cancel from any state (including LOAD) returns to EMPTY with load_n=1.
- Start and key together in ENTRY: start wins, key is dropped.

Other rules:
- key_err is registered, high for exactly one cycle per offending event.
- Digits are only ever 0..9.
- Reset mid-LOAD deasserts load_n immediately (asynchronous).

Test Plan:
- Reset, then press key 1, release, key 3, key 0, then start -> digits 1/3/0 (min/tens/units), digit_cnt=3, load_n low exactly 1 cycle, then busy=1.
- Press 1,2,3,4 -> min=1, tens=2, units=3, key_err one pulse on the 4th key.
- Enter 7,5 (tens=7), start -> key_err pulse, no load_n, state stays ENTRY; cancel -> digits 0, digit_cnt 0.
- Press keys 2 and 5 together -> key_err pulse, no shift; hold key 4 for 20 cycles -> exactly one shift.
- In HOLD, press key 8 and start -> no change, no key_err; done pulse -> EMPTY, digits 0, busy 0.
- Start alone in EMPTY -> key_err; enable=0 with key 6 -> no shift; cancel same cycle as start in ENTRY -> EMPTY, load_n stays 1; clear low during LOAD -> load_n=1 immediately.
